// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: walks a display-clipped rectangle in row-major order
// and issues one pixel write per covered pixel, in fill or outline mode.
module rect_draw_engine #(
  parameter int DISP_WIDTH   = 240,
  parameter int DISP_HEIGHT  = 320,
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 9,
  parameter int COLOUR_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       mode,
  input  logic [X_WIDTH-1:0]         xOrigin,
  input  logic [Y_WIDTH-1:0]         yOrigin,
  input  logic [X_WIDTH-1:0]         width,
  input  logic [Y_WIDTH-1:0]         height,
  input  logic [COLOUR_WIDTH-1:0]    colour,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic                       clipped,
  output logic [X_WIDTH+Y_WIDTH-1:0] pixelCount,
  output logic [X_WIDTH-1:0]         xAddr,
  output logic [Y_WIDTH-1:0]         yAddr,
  output logic [COLOUR_WIDTH-1:0]    pixelData,
  output logic                       pixelWrite,
  input  logic                       pixelReady
);

  localparam int CW = X_WIDTH + Y_WIDTH;
  localparam logic [X_WIDTH:0] X_MAX = (X_WIDTH+1)'(DISP_WIDTH - 1);
  localparam logic [Y_WIDTH:0] Y_MAX = (Y_WIDTH+1)'(DISP_HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WRITE = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                  state_r, state_next_s;
  logic                    armed_r, abort_r, mode_r;
  logic [X_WIDTH-1:0]      x_org_r, w_r;
  logic [Y_WIDTH-1:0]      y_org_r, h_r;
  logic [COLOUR_WIDTH-1:0] colour_r;
  logic [X_WIDTH:0]        x_last_r, x_end_r, x_last_s, x_end_s;
  logic [Y_WIDTH:0]        y_last_r, y_end_r, y_last_s, y_end_s;
  logic start_s, accept_s, empty_s, oor_s, clip_s;
  logic row_full_s, x_jump_s, x_step_s, y_step_s;

  assign ready = armed_r;

  // Armed implies IDLE, so the arm flag itself is the ready output.
  assign start_s  = (state_r == IDLE) && armed_r && start;
  assign accept_s = (state_r == WRITE) && pixelWrite && pixelReady;

  assign x_last_s = {1'b0, x_org_r} + {1'b0, w_r} - (X_WIDTH+1)'(1);
  assign y_last_s = {1'b0, y_org_r} + {1'b0, h_r} - (Y_WIDTH+1)'(1);
  assign x_end_s  = (x_last_s > X_MAX) ? X_MAX : x_last_s;
  assign y_end_s  = (y_last_s > Y_MAX) ? Y_MAX : y_last_s;
  assign oor_s    = ({1'b0, x_org_r} > X_MAX) || ({1'b0, y_org_r} > Y_MAX);
  assign empty_s  = (w_r == '0) || (h_r == '0) || oor_s;
  assign clip_s   = oor_s || (!empty_s && ((x_last_s > X_MAX) || (y_last_s > Y_MAX)));

  // Outline interior rows visit only xOrigin and, if still on screen, xLast.
  assign row_full_s = !mode_r || (yAddr == y_org_r) || ({1'b0, yAddr} == y_last_r);
  assign x_jump_s   = !row_full_s && (xAddr == x_org_r) && (x_last_r <= x_end_r) &&
                      (x_last_r != {1'b0, x_org_r});
  assign x_step_s   = row_full_s && ({1'b0, xAddr} < x_end_r);
  assign y_step_s   = ({1'b0, yAddr} < y_end_r);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_next_s = SETUP;
        else         state_next_s = IDLE;
      end
      SETUP: begin
        if (abort || empty_s) state_next_s = DONE;
        else                  state_next_s = WRITE;
      end
      WRITE: begin
        if (!accept_s)              state_next_s = WRITE;
        else if (abort || abort_r)  state_next_s = DONE;
        else                        state_next_s = NEXT;
      end
      NEXT: begin
        if (abort)                                   state_next_s = DONE;
        else if (x_jump_s || x_step_s || y_step_s)   state_next_s = WRITE;
        else                                         state_next_s = DONE;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath and registered outputs, all driven from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed_r    <= 1'b0;
      abort_r    <= 1'b0;
      mode_r     <= 1'b0;
      x_org_r    <= '0;
      y_org_r    <= '0;
      w_r        <= '0;
      h_r        <= '0;
      colour_r   <= '0;
      x_last_r   <= '0;
      y_last_r   <= '0;
      x_end_r    <= '0;
      y_end_r    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      clipped    <= 1'b0;
      pixelCount <= '0;
      xAddr      <= '0;
      yAddr      <= '0;
      pixelData  <= '0;
      pixelWrite <= 1'b0;
    end else begin
      pixelWrite <= (state_next_s == WRITE);
      done       <= (state_next_s == DONE);
      busy       <= (state_next_s == SETUP) || (state_next_s == WRITE) ||
                    (state_next_s == NEXT);
      if (start_s)                                armed_r <= 1'b0;
      else if ((state_next_s == IDLE) && !start)  armed_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            x_org_r    <= xOrigin;
            y_org_r    <= yOrigin;
            w_r        <= width;
            h_r        <= height;
            mode_r     <= mode;
            colour_r   <= colour;
            clipped    <= 1'b0;
            pixelCount <= '0;
            abort_r    <= 1'b0;
          end
        end
        SETUP: begin
          x_last_r <= x_last_s;
          y_last_r <= y_last_s;
          x_end_r  <= x_end_s;
          y_end_r  <= y_end_s;
          clipped  <= clip_s;
          if (state_next_s == WRITE) begin
            xAddr     <= x_org_r;
            yAddr     <= y_org_r;
            pixelData <= colour_r;
          end
        end
        WRITE: begin
          if (abort)    abort_r    <= 1'b1;
          if (accept_s) pixelCount <= pixelCount + CW'(1);
        end
        NEXT: begin
          if (state_next_s == WRITE) begin
            if (x_jump_s) begin
              xAddr <= x_last_r[X_WIDTH-1:0];
            end else if (x_step_s) begin
              xAddr <= xAddr + X_WIDTH'(1);
            end else begin
              xAddr <= x_org_r;
              yAddr <= yAddr + Y_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_draw_engine.sv
// Directed bench for rect_draw_engine: table of draws plus hand-written
// sequences for held start, backpressure, abort and mid-draw reset.
module tb_rect_draw_engine;

  logic        clock = 1'b0, reset, start, abort, mode, pixelReady;
  logic [7:0]  xOrigin, width, xAddr;
  logic [8:0]  yOrigin, height, yAddr;
  logic [15:0] colour, pixelData;
  logic        ready, busy, done, clipped, pixelWrite;
  logic [16:0] pixelCount;

  rect_draw_engine dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .xOrigin(xOrigin), .yOrigin(yOrigin), .width(width), .height(height),
    .colour(colour), .ready(ready), .busy(busy), .done(done), .clipped(clipped),
    .pixelCount(pixelCount), .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
    .pixelWrite(pixelWrite), .pixelReady(pixelReady)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        mode;
    int          x, y, w, h;
    logic [15:0] col;
    int          n, clip, lat, fx, fy, lx, ly;
  } vec_t;

  vec_t vecs[11];
  int   checks = 0, errors = 0;
  int   px[64], py[64], pd[64];
  int   draw_nw, draw_lat;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int cyc = 0;
    while (!ready && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("ready_before_draw", ready, 1);
  endtask

  // Launch a draw from a negedge and log every accepted write until done.
  task automatic run_draw(input vec_t v, input bit hold);
    int cyc = 0;
    bit got = 1'b0;
    for (int k = 0; k < 64; k++) begin px[k] = -1; py[k] = -1; pd[k] = -1; end
    draw_nw = 0;
    draw_lat = -1;
    wait_ready();
    mode = v.mode; xOrigin = 8'(v.x); yOrigin = 9'(v.y);
    width = 8'(v.w); height = 9'(v.h); colour = v.col;
    start = 1'b1;
    @(posedge clock);
    while (!got && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (!hold) start = 1'b0;
      if (pixelWrite && pixelReady && draw_nw < 64) begin
        px[draw_nw] = int'(xAddr); py[draw_nw] = int'(yAddr); pd[draw_nw] = int'(pixelData);
        draw_nw++;
      end
      if (done) begin got = 1'b1; draw_lat = cyc; end
    end
  endtask

  initial begin
    int fill_x[6]     = '{10, 11, 12, 10, 11, 12};
    int fill_y[6]     = '{20, 20, 20, 21, 21, 21};
    int outline_x[10] = '{0, 1, 2, 3, 0, 3, 0, 1, 2, 3};
    int outline_y[10] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2};
    int cyc, bad, extra;
    bit seen;

    // mode, x, y, w, h, colour, writes, clipped, latency, first xy, last xy
    vecs[0]  = '{1'b0,  10,  20, 3, 2, 16'hF800,  6, 0, 14,  10,  20,  12,  21};
    vecs[1]  = '{1'b1,   0,   0, 4, 3, 16'h07E0, 10, 0, 22,   0,   0,   3,   2};
    vecs[2]  = '{1'b0, 238, 318, 5, 5, 16'h001F,  4, 1, 10, 238, 318, 239, 319};
    vecs[3]  = '{1'b0, 240,   0, 2, 2, 16'hFFFF,  0, 1,  2,   0,   0,   0,   0};
    vecs[4]  = '{1'b0,   5,   5, 0, 3, 16'hAAAA,  0, 0,  2,   0,   0,   0,   0};
    vecs[5]  = '{1'b0,   5, 320, 1, 1, 16'h5555,  0, 1,  2,   0,   0,   0,   0};
    vecs[6]  = '{1'b1, 100, 100, 1, 3, 16'h1111,  3, 0,  8, 100, 100, 100, 102};
    vecs[7]  = '{1'b1,  50,  60, 3, 1, 16'h2222,  3, 0,  8,  50,  60,  52,  60};
    vecs[8]  = '{1'b1, 237,   0, 5, 3, 16'h3333,  7, 1, 16, 237,   0, 239,   2};
    vecs[9]  = '{1'b0,   0, 319, 2, 3, 16'h4444,  2, 1,  6,   0, 319,   1, 319};
    vecs[10] = '{1'b1,   0, 318, 3, 4, 16'h6666,  5, 1, 12,   0, 318,   2, 319};

    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; pixelReady = 1'b1;
    xOrigin = '0; yOrigin = '0; width = '0; height = '0; colour = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_ready", ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pixelWrite", pixelWrite, 0);
    check("reset_outputs_zero", int'(clipped) + int'(pixelCount) + int'(xAddr) +
          int'(yAddr) + int'(pixelData), 0);
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", ready, 1);

    for (int i = 0; i < 11; i++) begin
      run_draw(vecs[i], 1'b0);
      check($sformatf("v%0d_writes", i), draw_nw, vecs[i].n);
      check($sformatf("v%0d_latency", i), draw_lat, vecs[i].lat);
      check($sformatf("v%0d_pixelCount", i), int'(pixelCount), vecs[i].n);
      check($sformatf("v%0d_clipped", i), int'(clipped), vecs[i].clip);
      if (vecs[i].n > 0) begin
        check($sformatf("v%0d_first_x", i), px[0], vecs[i].fx);
        check($sformatf("v%0d_first_y", i), py[0], vecs[i].fy);
        check($sformatf("v%0d_last_x", i), px[vecs[i].n-1], vecs[i].lx);
        check($sformatf("v%0d_last_y", i), py[vecs[i].n-1], vecs[i].ly);
        check($sformatf("v%0d_colour", i), pd[0], int'(vecs[i].col));
      end
      if (i == 0)
        for (int k = 0; k < 6; k++) begin
          check($sformatf("fill_order_%0d", k), px[k], fill_x[k]);
          check($sformatf("fill_order_y%0d", k), py[k], fill_y[k]);
        end
      if (i == 1)
        for (int k = 0; k < 10; k++) begin
          check($sformatf("outline_order_%0d", k), px[k], outline_x[k]);
          check($sformatf("outline_order_y%0d", k), py[k], outline_y[k]);
        end
    end

    // Start held high across a zero-size draw must not retrigger.
    run_draw(vecs[4], 1'b1);
    check("held_latency", draw_lat, 2);
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (ready || busy || pixelWrite) bad++;
    end
    check("held_start_no_retrigger", bad, 0);
    start = 1'b0;
    @(negedge clock);
    check("rearm_after_start_low", ready, 1);

    // Backpressure: the pending write must hold still until accepted.
    wait_ready();
    mode = 1'b0; xOrigin = 8'd30; yOrigin = 9'd40; width = 8'd2; height = 9'd1;
    colour = 16'h1234; pixelReady = 1'b0; start = 1'b1;
    @(posedge clock);
    @(negedge clock) start = 1'b0;
    cyc = 0;
    while (!pixelWrite && cyc < 20) begin @(negedge clock); cyc++; end
    check("bp_write_raised", pixelWrite, 1);
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (xAddr != 8'd30 || yAddr != 9'd40 || pixelData != 16'h1234 || !pixelWrite) bad++;
    end
    check("bp_request_stable", bad, 0);
    check("bp_count_unchanged", int'(pixelCount), 0);
    pixelReady = 1'b1;
    @(negedge clock);
    check("bp_accepted_count", int'(pixelCount), 1);
    check("bp_write_dropped", pixelWrite, 0);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin @(negedge clock); cyc++; seen = done; end
    check("bp_done", seen, 1);
    check("bp_final_count", int'(pixelCount), 2);

    // Abort after the seventh accepted write of a 10x10 fill.
    wait_ready();
    mode = 1'b0; xOrigin = 8'd0; yOrigin = 9'd0; width = 8'd10; height = 9'd10;
    colour = 16'hF0F0; start = 1'b1;
    @(posedge clock);
    @(negedge clock) start = 1'b0;
    cyc = 0;
    while (pixelCount != 17'd7 && cyc < 100) begin @(negedge clock); cyc++; end
    check("abort_reached_7", int'(pixelCount), 7);
    abort = 1'b1;
    cyc = 0; seen = 1'b0; extra = 0;
    while (!seen && cyc < 50) begin
      if (pixelWrite && pixelReady) extra++;
      @(negedge clock);
      cyc++;
      seen = done;
    end
    abort = 1'b0;
    check("abort_done", seen, 1);
    check("abort_extra_writes_le1", int'(extra <= 1), 1);
    check("abort_count_le8", int'(pixelCount <= 17'd8), 1);

    // Reset mid-draw clears outputs without a clock edge.
    wait_ready();
    xOrigin = 8'd0; yOrigin = 9'd0; width = 8'd10; height = 9'd10; start = 1'b1;
    @(posedge clock);
    @(negedge clock) start = 1'b0;
    cyc = 0;
    while (!pixelWrite && cyc < 20) begin @(negedge clock); cyc++; end
    check("mid_draw_write_active", pixelWrite, 1);
    reset = 1'b1;
    #1;
    check("mid_reset_pixelWrite", pixelWrite, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_ready", ready, 0);
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    check("ready_after_mid_reset", ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
